// File: rtl/mac_array_ctrl_pkg.sv
// Shared types and constants for the MAC array tile sequencer.
// Holds the FSM state encoding and the inst_w opcode values.
package mac_array_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GAP,
    ST_EXEC,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [1:0] INST_NOP  = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  // Width of a counter that must hold 0..max(a,b)-1, never narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/mac_array_ctrl.sv
// Tile sequencer: loads one kernel tile into the 8x8 MAC array, waits for the
// inst_w chain to settle, streams input vectors, then counts south-edge outputs.
module mac_array_ctrl
  import mac_array_ctrl_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode_cfg,
  input  logic [len_bw-1:0]  num_vec,
  input  logic [addr_bw-1:0] base_addr,
  input  logic               stall,
  input  logic [col-1:0]     array_valid,
  output logic [1:0]         inst_w,
  output logic               ws_os_mode,
  output logic               mem_cen,
  output logic [addr_bw-1:0] mem_addr,
  output logic               busy,
  output logic               done,
  output logic [len_bw-1:0]  out_cnt
);

  localparam int PH_W = cnt_width(row, col);

  state_t             state, state_d;
  logic [PH_W-1:0]    phase, phase_d;
  logic [len_bw-1:0]  issue_cnt, issue_d;
  logic [len_bw-1:0]  nv_q;
  logic [addr_bw-1:0] base_q;
  logic [addr_bw-1:0] addr_d;
  logic [len_bw-1:0]  cnt_d;
  logic [1:0]         inst_d;
  logic               cen_d;
  logic               accept;
  logic               cnt_inc;

  // Only the last column marks a completed output; the rest are observed for lint hygiene.
  logic unused_valid;
  assign unused_valid = ^array_valid;

  assign cnt_inc = array_valid[col-1] && (out_cnt < nv_q) &&
                   ((state == ST_EXEC) || (state == ST_DRAIN));

  always_comb begin
    // NOTE: every variable gets a default here so no path leaves it unassigned (no latch).
    state_d = state;
    phase_d = phase;
    issue_d = issue_cnt;
    cen_d   = 1'b1;
    addr_d  = mem_addr;
    cnt_d   = out_cnt + len_bw'(cnt_inc);
    accept  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && (num_vec != '0)) begin
          accept  = 1'b1;
          state_d = ST_LOAD;
          phase_d = '0;
          issue_d = '0;
          cen_d   = 1'b0;
          addr_d  = base_addr;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (phase == PH_W'(col - 1)) begin
          state_d = ST_GAP;
          phase_d = '0;
        end else begin
          phase_d = phase + PH_W'(1);
          cen_d   = 1'b0;
          addr_d  = mem_addr + addr_bw'(1);
        end
      end
      ST_GAP: begin
        // Idle long enough for the last load opcode to reach the bottom row.
        if (phase == PH_W'(row - 1)) begin
          state_d = ST_EXEC;
          phase_d = '0;
          issue_d = len_bw'(1);
          cen_d   = 1'b0;
          addr_d  = base_q + addr_bw'(col);
        end else begin
          phase_d = phase + PH_W'(1);
        end
      end
      ST_EXEC: begin
        // mem_addr always holds the last issued address, so resuming is just +1.
        if (issue_cnt == nv_q) begin
          state_d = ST_DRAIN;
        end else if (!stall) begin
          issue_d = issue_cnt + len_bw'(1);
          cen_d   = 1'b0;
          addr_d  = mem_addr + addr_bw'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_d == nv_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Opcode trails the SRAM read by one cycle so it lines up with the returned data.
    inst_d = INST_NOP;
    if (!mem_cen) inst_d = (state == ST_LOAD) ? INST_LOAD : INST_EXEC;
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset) begin
      state      <= ST_IDLE;
      phase      <= '0;
      issue_cnt  <= '0;
      nv_q       <= '0;
      base_q     <= '0;
      inst_w     <= INST_NOP;
      ws_os_mode <= 1'b0;
      mem_cen    <= 1'b1;
      mem_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      out_cnt    <= '0;
    end else begin
      state     <= state_d;
      phase     <= phase_d;
      issue_cnt <= issue_d;
      inst_w    <= inst_d;
      mem_cen   <= cen_d;
      mem_addr  <= addr_d;
      busy      <= (state_d != ST_IDLE);
      done      <= (state_d == ST_DONE);
      out_cnt   <= cnt_d;
      if (accept) begin
        nv_q       <= num_vec;
        base_q     <= base_addr;
        ws_os_mode <= mode_cfg;
      end
    end
  end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl: scoreboard of expected SRAM reads,
// per-cycle inst_w check, directed tiles covering stall, wrap, saturation and reset.
module tb_mac_array_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam logic [1:0] K_NOP  = 2'b00;
  localparam logic [1:0] K_LOAD = 2'b01;
  localparam logic [1:0] K_EXEC = 2'b10;

  typedef struct packed {
    logic [1:0]  kind;
    logic [10:0] addr;
  } rd_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mode_cfg = 1'b0;
  logic [7:0]  num_vec = '0;
  logic [10:0] base_addr = '0;
  logic        stall = 1'b0;
  logic [7:0]  array_valid = '0;
  logic [1:0]  inst_w;
  logic        ws_os_mode;
  logic        mem_cen;
  logic [10:0] mem_addr;
  logic        busy;
  logic        done;
  logic [7:0]  out_cnt;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  rd_t  exp_q[$];
  rd_t  e;
  logic rst_seen = 1'b0;
  logic prev_read = 1'b0;
  logic [1:0] prev_kind = K_NOP;
  int   load_seen, exec_seen, done_cnt, first_load_cyc, first_exec_cyc;
  logic [7:0] done_out_cnt;

  mac_array_ctrl #(.row(ROW), .col(COL), .addr_bw(11), .len_bw(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode_cfg(mode_cfg),
    .num_vec(num_vec), .base_addr(base_addr), .stall(stall),
    .array_valid(array_valid), .inst_w(inst_w), .ws_os_mode(ws_os_mode),
    .mem_cen(mem_cen), .mem_addr(mem_addr), .busy(busy), .done(done),
    .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Monitor: every read must match the scoreboard head, and inst_w must echo it a cycle later.
  always @(negedge clk) begin
    if (rst_seen) begin
      check("inst_w", {30'd0, inst_w}, {30'd0, (prev_read ? prev_kind : K_NOP)});
      prev_read = 1'b0;
      if (mem_cen === 1'b0) begin
        check("read_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("mem_addr", {21'd0, mem_addr}, {21'd0, e.addr});
          prev_read = 1'b1;
          prev_kind = e.kind;
          if (e.kind == K_LOAD) begin
            if (load_seen == 0) first_load_cyc = cyc;
            load_seen++;
          end else begin
            if (exec_seen == 0) first_exec_cyc = cyc;
            exec_seen++;
          end
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_out_cnt = out_cnt;
      end
    end else begin
      prev_read = 1'b0;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic tile(input logic [10:0] base, input logic [7:0] nv, input logic mode,
                      input bit do_stall, input int extra, input bit poke);
    int t0;
    logic [10:0] a;
    for (int k = 0; k < COL; k++) begin
      a = base + 11'(k);
      exp_q.push_back('{kind: K_LOAD, addr: a});
    end
    for (int v = 0; v < int'(nv); v++) begin
      a = base + 11'(COL) + 11'(v);
      exp_q.push_back('{kind: K_EXEC, addr: a});
    end
    load_seen = 0; exec_seen = 0; done_cnt = 0;
    first_load_cyc = -1; first_exec_cyc = -1;
    base_addr = base; num_vec = nv; mode_cfg = mode; start = 1'b1;
    t0 = cyc;
    step();
    start = 1'b0;
    base_addr = 11'($urandom);
    num_vec = 8'($urandom);
    mode_cfg = ~mode;
    check("busy_rise", {31'd0, busy}, 32'd1);
    check("mode_latched", {31'd0, ws_os_mode}, {31'd0, mode});

    if (poke) begin
      for (int i = 0; i < 200 && exec_seen < 1; i++) step();
      check("poke_reach_exec", {31'd0, exec_seen >= 1}, 32'd1);
      start = 1'b1; num_vec = nv + 8'd3; base_addr = 11'h555; mode_cfg = ~mode;
      step();
      start = 1'b0;
    end

    if (do_stall) begin
      for (int i = 0; i < 200 && exec_seen < 2; i++) step();
      check("stall_reach_exec2", exec_seen, 32'd2);
      stall = 1'b1;
      a = base + 11'(COL) + 11'd1;
      for (int i = 0; i < 3; i++) begin
        step();
        check("stall_cen", {31'd0, mem_cen}, 32'd1);
        check("stall_addr_hold", {21'd0, mem_addr}, {21'd0, a});
      end
      stall = 1'b0;
    end

    for (int i = 0; i < 300 && exec_seen < int'(nv); i++) step();
    check("exec_count", exec_seen, {24'd0, nv});

    // Array model: a completed output every other cycle, other columns noisy in between.
    for (int i = 0; i < int'(nv) + extra; i++) begin
      array_valid = 8'h80 | 8'($urandom);
      step();
      array_valid = 8'h7F;
      step();
    end
    array_valid = '0;
    for (int i = 0; i < 50 && done_cnt < 1; i++) step();
    step(); step(); step();

    check("done_once", done_cnt, 32'd1);
    check("out_cnt_at_done", {24'd0, done_out_cnt}, {24'd0, nv});
    check("out_cnt_after", {24'd0, out_cnt}, {24'd0, nv});
    check("busy_fall", {31'd0, busy}, 32'd0);
    check("load_count", load_seen, COL);
    check("queue_drained", exp_q.size(), 32'd0);
    check("first_load_cyc", first_load_cyc, t0 + 1);
    if (!do_stall && !poke) check("first_exec_cyc", first_exec_cyc, t0 + COL + ROW + 1);
    check("mode_hold", {31'd0, ws_os_mode}, {31'd0, mode});
  endtask

  initial begin
    load_seen = 0; exec_seen = 0; done_cnt = 0;
    first_load_cyc = -1; first_exec_cyc = -1; done_out_cnt = '0;

    // Reset values
    step(); step(); step();
    check("rst_inst_w", {30'd0, inst_w}, 32'd0);
    check("rst_mode", {31'd0, ws_os_mode}, 32'd0);
    check("rst_cen", {31'd0, mem_cen}, 32'd1);
    check("rst_addr", {21'd0, mem_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_out_cnt", {24'd0, out_cnt}, 32'd0);
    reset = 1'b1;
    step();

    // Start with zero vectors is ignored
    base_addr = 11'h123; num_vec = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("nv0_busy", {31'd0, busy}, 32'd0);
      check("nv0_cen", {31'd0, mem_cen}, 32'd1);
    end
    check("nv0_no_done", done_cnt, 32'd0);

    // Basic tile, stalled tile, mode tile with ignored mid-tile start, wrapping tile
    tile(11'h010, 8'd4, 1'b0, 1'b0, 0, 1'b0);
    tile(11'h100, 8'd6, 1'b0, 1'b1, 0, 1'b0);
    tile(11'h200, 8'd3, 1'b1, 1'b0, 0, 1'b1);
    step(); step();
    check("mode_idle_hold", {31'd0, ws_os_mode}, 32'd1);
    tile(11'h7FC, 8'd3, 1'b0, 1'b0, 2, 1'b0);

    // Reset in the middle of EXEC abandons the tile
    for (int k = 0; k < COL; k++) exp_q.push_back('{kind: K_LOAD, addr: 11'h040 + 11'(k)});
    for (int v = 0; v < 5; v++) exp_q.push_back('{kind: K_EXEC, addr: 11'h048 + 11'(v)});
    load_seen = 0; exec_seen = 0; done_cnt = 0;
    base_addr = 11'h040; num_vec = 8'd5; mode_cfg = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 200 && exec_seen < 1; i++) step();
    check("rstmid_reach_exec", {31'd0, exec_seen >= 1}, 32'd1);
    array_valid = 8'h80;
    step();
    array_valid = '0;
    check("rstmid_cnt_pre", {24'd0, out_cnt}, 32'd1);
    reset = 1'b0;
    step();
    check("rstmid_inst_w", {30'd0, inst_w}, 32'd0);
    check("rstmid_cen", {31'd0, mem_cen}, 32'd1);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_out_cnt", {24'd0, out_cnt}, 32'd0);
    check("rstmid_mode", {31'd0, ws_os_mode}, 32'd0);
    step(); step();
    reset = 1'b1;
    exp_q.delete();
    step(); step();
    check("rstmid_idle_busy", {31'd0, busy}, 32'd0);
    check("rstmid_idle_cen", {31'd0, mem_cen}, 32'd1);

    // Recovery after reset with a single-vector tile
    tile(11'h3F0, 8'd1, 1'b1, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
